mic_peak_meter: RTL and testbench

Sits directly downstream of the microphone sampler and consumes its 12-bit samples. Turns each sample into an offset-removed magnitude, tracks the peak over a fixed window, and quantises the peak to a 0–9 loudness level with a one-step-per-window decay. Drives the 9-LED volume bar and the level digit sent to the 7-segment driver.

---
 rtl/mic_meter_pkg.sv | 46 ++++
 rtl/mic_abs_magnitude.sv | 27 ++
 rtl/mic_peak_meter.sv | 94 +++++++++
 tb/tb_mic_peak_meter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mic_meter_pkg.sv
// Shared constants, state encoding and level helpers for the microphone peak meter.
// Thresholds step by 205 so that 9 levels span roughly the full 11-bit magnitude range.
package mic_meter_pkg;

  localparam int MIC_MID    = 2048;
  localparam int MAG_MAX    = 2047;
  localparam int MAG_W      = 11;
  localparam int NUM_LEVELS = 9;

  localparam logic [MAG_W-1:0] T1 = 11'd205;
  localparam logic [MAG_W-1:0] T2 = 11'd410;
  localparam logic [MAG_W-1:0] T3 = 11'd615;
  localparam logic [MAG_W-1:0] T4 = 11'd820;
  localparam logic [MAG_W-1:0] T5 = 11'd1025;
  localparam logic [MAG_W-1:0] T6 = 11'd1230;
  localparam logic [MAG_W-1:0] T7 = 11'd1435;
  localparam logic [MAG_W-1:0] T8 = 11'd1640;
  localparam logic [MAG_W-1:0] T9 = 11'd1845;

  typedef enum logic {
    ACCUM   = 1'b0,
    PUBLISH = 1'b1
  } meter_state_e;

  // Number of thresholds at or below the peak, 0..9.
  function automatic logic [3:0] peak_to_level(input logic [MAG_W-1:0] pk);
    logic [MAG_W-1:0] thresh [NUM_LEVELS];
    logic [3:0]       n;
    thresh = '{T1, T2, T3, T4, T5, T6, T7, T8, T9};
    n = 4'd0;
    for (int k = 0; k < NUM_LEVELS; k++) begin
      if (pk >= thresh[k]) n = n + 4'd1;
    end
    return n;
  endfunction

  function automatic logic [NUM_LEVELS-1:0] level_to_bar(input logic [3:0] lvl);
    logic [NUM_LEVELS-1:0] bar;
    bar = '0;
    for (int k = 0; k < NUM_LEVELS; k++) begin
      bar[k] = (lvl > 4'(k));
    end
    return bar;
  endfunction

endpackage

// File: rtl/mic_abs_magnitude.sv
// Offset-removed magnitude of an unsigned mid-scale sample, saturated to 11 bits.
// Purely combinational so other audio blocks can drop it into their own pipelines.
module mic_abs_magnitude
  import mic_meter_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic [SAMPLE_W-1:0] sample,
  output logic [MAG_W-1:0]    mag
);

  localparam logic [SAMPLE_W:0] MID_W = (SAMPLE_W+1)'(MIC_MID);
  localparam logic [SAMPLE_W:0] MAX_W = (SAMPLE_W+1)'(MAG_MAX);

  logic [SAMPLE_W:0] sample_x;
  logic [SAMPLE_W:0] diff;

  always_comb begin
    sample_x = {1'b0, sample};
    if (sample_x >= MID_W) diff = sample_x - MID_W;
    else                   diff = MID_W - sample_x;
    // Only the most negative sample can exceed the 11-bit range.
    if (diff > MAX_W) mag = MAG_W'(MAG_MAX);
    else              mag = diff[MAG_W-1:0];
  end

endmodule

// File: rtl/mic_peak_meter.sv
// Windowed peak meter: tracks the peak magnitude over WINDOW samples and publishes
// a decaying 0-9 loudness level, LED thermometer bar and the raw peak once per window.
//
// state   | meaning
// ACCUM   | accepting samples, folding magnitude into the running peak
// PUBLISH | one cycle: register peak/level/bar, pulse level_valid, restart window
module mic_peak_meter
  import mic_meter_pkg::*;
#(
  parameter int WINDOW   = 4000,
  parameter int SAMPLE_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample,
  output logic [3:0]            level,
  output logic [NUM_LEVELS-1:0] led_bar,
  output logic [MAG_W-1:0]      peak,
  output logic                  level_valid
);

  localparam int               CNT_W    = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  meter_state_e     state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [MAG_W-1:0] acc, acc_next;
  logic [MAG_W-1:0] mag;
  logic             publish;
  logic [3:0]       lvl_new, lvl_decay, lvl_next;

  mic_abs_magnitude #(.SAMPLE_W(SAMPLE_W)) u_mag (
    .sample (sample),
    .mag    (mag)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    acc_next   = acc;
    publish    = 1'b0;
    case (state)
      ACCUM: begin
        if (sample_valid) begin
          acc_next = (mag > acc) ? mag : acc;
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = PUBLISH;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      PUBLISH: begin
        publish    = 1'b1;
        state_next = ACCUM;
        // A strobe landing here opens the next window rather than being lost.
        acc_next   = sample_valid ? mag : '0;
        cnt_next   = sample_valid ? CNT_W'(1) : '0;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    lvl_new   = peak_to_level(acc);
    lvl_decay = (level == 4'd0) ? 4'd0 : level - 4'd1;
    lvl_next  = (lvl_new > lvl_decay) ? lvl_new : lvl_decay;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      cnt         <= '0;
      acc         <= '0;
      level       <= 4'd0;
      led_bar     <= '0;
      peak        <= '0;
      level_valid <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      acc         <= acc_next;
      level_valid <= publish;
      if (publish) begin
        peak    <= acc;
        level   <= lvl_next;
        led_bar <= level_to_bar(lvl_next);
      end
    end
  end

endmodule

// File: tb/tb_mic_peak_meter.sv
// Directed self-checking bench for mic_peak_meter with WINDOW=4.
module tb_mic_peak_meter;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [11:0] sample;
  logic [3:0]  level;
  logic [8:0]  led_bar;
  logic [10:0] peak;
  logic        level_valid;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  mic_peak_meter #(.WINDOW(4), .SAMPLE_W(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (level),
    .led_bar      (led_bar),
    .peak         (peak),
    .level_valid  (level_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (level_valid) pulses++;
  end

  task automatic strobe(input logic [11:0] s, input int gap);
    sample_valid = 1'b1;
    sample       = s;
    @(negedge clk);
    sample_valid = 1'b0;
    sample       = 12'h5A5;
    repeat (gap) @(negedge clk);
  endtask

  // Wait (bounded) until the pulse count reaches target, then let stragglers show up.
  task automatic wait_pulses(input string name, input int target);
    int n;
    n = 0;
    while (pulses < target && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pulses !== target) begin
      errors++;
      $display("FAIL %s pulse count: got %0d expected %0d", name, pulses, target);
    end
  endtask

  task automatic check_out(input string name, input logic [10:0] e_peak,
                           input logic [3:0] e_level, input logic [8:0] e_bar);
    checks++;
    if (peak !== e_peak) begin
      errors++;
      $display("FAIL %s peak: got %0d expected %0d", name, peak, e_peak);
    end
    checks++;
    if (level !== e_level) begin
      errors++;
      $display("FAIL %s level: got %0d expected %0d", name, level, e_level);
    end
    checks++;
    if (led_bar !== e_bar) begin
      errors++;
      $display("FAIL %s led_bar: got %b expected %b", name, led_bar, e_bar);
    end
  endtask

  task automatic test_reset;
    int p0;
    check_out("reset_init", 11'd0, 4'd0, 9'h000);
    checks++;
    if (level_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_init level_valid: got %b expected 0", level_valid);
    end
    // Drive to level 9 so the mid-window reset has something to clear.
    p0 = pulses;
    strobe(12'd2048, 1); strobe(12'd0, 1); strobe(12'd2048, 1); strobe(12'd2048, 1);
    wait_pulses("reset_prefill", p0 + 1);
    check_out("reset_prefill", 11'd2047, 4'd9, 9'h1FF);
    // Partial window of loud samples, then asynchronous reset between edges.
    strobe(12'd0, 1); strobe(12'd0, 0);
    #2 rst = 1'b1;
    #1;
    check_out("reset_async", 11'd0, 4'd0, 9'h000);
    checks++;
    if (level_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async level_valid: got %b expected 0", level_valid);
    end
    @(negedge clk);
    sample_valid = 1'b1; sample = 12'd0;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    p0 = pulses;
    strobe(12'd2048, 1); strobe(12'd2048, 1); strobe(12'd2048, 1);
    repeat (4) @(negedge clk);
    checks++;
    if (pulses !== p0) begin
      errors++;
      $display("FAIL reset_partial_discarded pulses: got %0d expected %0d", pulses, p0);
    end
    strobe(12'd2048, 1);
    wait_pulses("reset_first_window", p0 + 1);
    check_out("reset_first_window", 11'd0, 4'd0, 9'h000);
  endtask

  task automatic test_quantise;
    int p0;
    p0 = pulses;
    strobe(12'd2048, 0); strobe(12'd2100, 0); strobe(12'd2600, 0); strobe(12'd2048, 0);
    wait_pulses("quantise", p0 + 1);
    check_out("quantise", 11'd552, 4'd2, 9'b000000011);
  endtask

  task automatic test_saturation;
    int p0;
    p0 = pulses;
    strobe(12'd2048, 2); strobe(12'd0, 2); strobe(12'd2047, 2); strobe(12'd2049, 2);
    wait_pulses("saturation", p0 + 1);
    check_out("saturation", 11'd2047, 4'd9, 9'h1FF);
  endtask

  task automatic test_decay;
    int p0;
    logic [3:0] exp_lvl;
    logic [8:0] bar;
    exp_lvl = 4'd9;
    for (int w = 0; w < 3; w++) begin
      p0 = pulses;
      for (int i = 0; i < 4; i++) strobe(12'd2048, 1);
      wait_pulses("decay", p0 + 1);
      exp_lvl = exp_lvl - 4'd1;
      bar = 9'h1FF >> (9 - exp_lvl);
      check_out("decay", 11'd0, exp_lvl, bar);
    end
    p0 = pulses;
    strobe(12'd2048, 1); strobe(12'd3948, 1); strobe(12'd2500, 1); strobe(12'd2048, 1);
    wait_pulses("decay_jump", p0 + 1);
    check_out("decay_jump", 11'd1900, 4'd9, 9'h1FF);
  endtask

  task automatic test_back_to_back;
    int p0;
    // Loud window closes; the strobe in PUBLISH must start a fresh accumulator.
    p0 = pulses;
    strobe(12'd2048, 1); strobe(12'd2048, 1); strobe(12'd2048, 1); strobe(12'd0, 0);
    strobe(12'd2100, 0); strobe(12'd2048, 0); strobe(12'd2048, 0); strobe(12'd2048, 0);
    wait_pulses("b2b_clear", p0 + 2);
    check_out("b2b_clear", 11'd52, 4'd8, 9'h0FF);
    // Quiet window closes; the PUBLISH-cycle strobe alone drives the next peak.
    p0 = pulses;
    strobe(12'd2048, 0); strobe(12'd2048, 0); strobe(12'd2048, 0); strobe(12'd2048, 0);
    strobe(12'd4095, 0); strobe(12'd2048, 0); strobe(12'd2048, 0); strobe(12'd2048, 0);
    wait_pulses("b2b_publish_strobe", p0 + 2);
    check_out("b2b_publish_strobe", 11'd2047, 4'd9, 9'h1FF);
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample       = 12'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_quantise;
    test_saturation;
    test_decay;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
